// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback controller: opcodes, register
// indices, status bit positions, FSM states and opcode classification helpers.
package alu_pkg;

  localparam logic [3:0] OP_ONES = 4'b0000;
  localparam logic [3:0] OP_PASS = 4'b0001;
  localparam logic [3:0] OP_INC  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_CMP  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_ADD  = 4'b1011;

  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_B = 2'd1;
  localparam logic [1:0] REG_C = 2'd2;
  localparam logic [1:0] REG_D = 2'd3;

  localparam int ST_BORROW = 0;
  localparam int ST_ZERO   = 1;
  localparam int ST_CARRY  = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WRITE, DONE} state_t;

  function automatic logic op_illegal(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

  function automatic logic op_writes(input logic [3:0] op);
    return !op_illegal(op) && (op != OP_CMP);
  endfunction

  // Flags are derived here rather than trusted from the ALU's sticky outputs.
  function automatic logic [7:0] calc_status(input logic [3:0] op,
                                             input logic       res_zero,
                                             input logic [7:0] alu_st);
    logic [7:0] st;
    st = '0;
    case (op)
      OP_ONES, OP_PASS, OP_INC, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD:
        st[ST_ZERO] = res_zero;
      default: st[ST_ZERO] = 1'b0;
    endcase
    if (op == OP_INC || op == OP_ADD) st[ST_CARRY] = alu_st[ST_CARRY];
    if (op == OP_SUB) st[ST_BORROW] = alu_st[ST_BORROW];
    return st;
  endfunction

endpackage

// File: rtl/regfile_4x8.sv
// Four-entry operand register file: one write port, all entries readable in parallel.
module regfile_4x8 #(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [1:0]             waddr,
  input  logic [DATA_W-1:0]      wdata,
  output logic [3:0][DATA_W-1:0] rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (we && waddr == 2'(gi)) begin
          entry_reg <= wdata;
        end
      end

      assign rdata[gi] = entry_reg;
    end
  endgenerate

endmodule

// File: rtl/alu_writeback_ctrl.sv
// Sequences commands to the combinational ALU and writes results back to A..D.
// Optional macro STATUS_STICKY_EN: OR-accumulate status bits, cleared by rst or a load to A.
module alu_writeback_ctrl
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int DATA_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_regsel,
  input  logic [3:0]        cmd_op,
  input  logic [1:0]        cmd_dst,
  input  logic              ld_valid,
  input  logic [1:0]        ld_sel,
  input  logic [DATA_W-1:0] ld_data,
  output logic [3:0]        alu_regsel,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [7:0]        alu_status,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic [DATA_W-1:0] reg_c,
  output logic [DATA_W-1:0] reg_d,
  output logic [7:0]        status,
  output logic              done,
  output logic              busy,
  output logic              err
);

  state_t                   state_reg, state_next;
  logic [3:0]               regsel_reg, op_reg;
  logic [1:0]               dst_reg;
  logic [2:0]               cnt_reg;
  logic [7:0]               status_reg, status_next, flags;
  logic                     accept, ld_we, wb_we;
  logic [3:0][DATA_W-1:0]   rf_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = !ld_valid && !rst;
        if (cmd_valid && cmd_ready) state_next = ISSUE;
      end
      ISSUE:   if (cnt_reg == 3'd0) state_next = WRITE;
      WRITE:   state_next = DONE;
      DONE: begin
        done       = 1'b1;
        err        = op_illegal(op_reg);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = cmd_valid && cmd_ready;
  assign ld_we  = (state_reg == IDLE) && ld_valid;
  assign wb_we  = (state_reg == WRITE) && op_writes(op_reg);
  assign flags  = calc_status(op_reg, alu_result == '0, alu_status);

  always_comb begin
    status_next = status_reg;
`ifdef STATUS_STICKY_EN
    if (ld_we && ld_sel == REG_A) status_next = '0;
    if (state_reg == WRITE && !op_illegal(op_reg)) status_next = status_reg | flags;
`else
    if (state_reg == WRITE && !op_illegal(op_reg)) status_next = flags;
`endif
  end

  // The latched command keeps driving the ALU until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regsel_reg <= '0;
      op_reg     <= '0;
      dst_reg    <= '0;
      cnt_reg    <= '0;
      status_reg <= '0;
    end else begin
      if (accept) begin
        regsel_reg <= cmd_regsel;
        op_reg     <= cmd_op;
        dst_reg    <= cmd_dst;
        cnt_reg    <= 3'(SETTLE_CYCLES - 1);
      end else if (state_reg == ISSUE && cnt_reg != 3'd0) begin
        cnt_reg <= cnt_reg - 3'd1;
      end
      status_reg <= status_next;
    end
  end

  // Load and writeback never coincide: loads only happen in IDLE.
  regfile_4x8 #(.DATA_W(DATA_W)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (ld_we || wb_we),
    .waddr (wb_we ? dst_reg : ld_sel),
    .wdata (wb_we ? alu_result : ld_data),
    .rdata (rf_rdata)
  );

  assign reg_a      = rf_rdata[REG_A];
  assign reg_b      = rf_rdata[REG_B];
  assign reg_c      = rf_rdata[REG_C];
  assign reg_d      = rf_rdata[REG_D];
  assign alu_regsel = regsel_reg;
  assign alu_op     = op_reg;
  assign status     = status_reg;

endmodule

// File: tb/tb_alu_writeback_ctrl.sv
// Randomized bench for alu_writeback_ctrl with a behavioural ALU and register-file model.
module tb_alu_writeback_ctrl;
  import alu_pkg::*;

  localparam int SETTLE = 1;

  logic       clk = 1'b0, rst = 1'b1;
  logic       cmd_valid = 1'b0, ld_valid = 1'b0;
  logic [3:0] cmd_regsel = '0, cmd_op = '0;
  logic [1:0] cmd_dst = '0, ld_sel = '0;
  logic [7:0] ld_data = '0;
  logic       cmd_ready, done, busy, err, alu_cy;
  logic [3:0] alu_regsel, alu_op;
  logic [7:0] alu_result, alu_status, reg_a, reg_b, reg_c, reg_d, status;
  logic [7:0] junk_st = '0;
  logic [7:0] rv [4];
  logic [7:0] m_reg [4];
  logic [7:0] m_status;
  int n_total = 0, n_bad = 0;

  alu_writeback_ctrl #(.SETTLE_CYCLES(SETTLE), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_regsel(cmd_regsel), .cmd_op(cmd_op), .cmd_dst(cmd_dst),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_data(ld_data),
    .alu_regsel(alu_regsel), .alu_op(alu_op), .alu_result(alu_result),
    .alu_status(alu_status), .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c),
    .reg_d(reg_d), .status(status), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) junk_st <= 8'($urandom);

  // {carry/borrow, result} of the ALU for one operation.
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:        return 9'h0FF;
      4'd1:        return {1'b0, a};
      4'd2:        return {1'b0, a} + 9'd1;
      4'd3, 4'd4:  return {1'b0, a} - {1'b0, b};
      4'd5:        return {1'b0, a & b};
      4'd6:        return {1'b0, a | b};
      4'd7:        return {1'b0, a ^ b};
      4'd8:        return {1'b0, ~a};
      4'd9:        return {a, 1'b0};
      4'd10:       return {1'b0, a >> 1};
      4'd11:       return {1'b0, a} + {1'b0, b};
      default:     return 9'h0AA;
    endcase
  endfunction

  // Upper status bits, and flags an op does not define, carry junk.
  always_comb begin
    rv[0] = reg_a; rv[1] = reg_b; rv[2] = reg_c; rv[3] = reg_d;
    {alu_cy, alu_result} = alu_f(alu_op, rv[alu_regsel[3:2]], rv[alu_regsel[1:0]]);
    alu_status = junk_st;
    alu_status[1] = (alu_result == 8'h00);
    if (alu_op == 4'd2 || alu_op == 4'd11) alu_status[2] = alu_cy;
    if (alu_op == 4'd3) alu_status[0] = alu_cy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("reg_a", reg_a, m_reg[0]);
    chk("reg_b", reg_b, m_reg[1]);
    chk("reg_c", reg_c, m_reg[2]);
    chk("reg_d", reg_d, m_reg[3]);
    chk("status", status, m_status);
  endtask

  task automatic do_load(input logic [1:0] sel, input logic [7:0] data);
    ld_valid = 1'b1; ld_sel = sel; ld_data = data;
    @(posedge clk); @(negedge clk);
    ld_valid = 1'b0;
    m_reg[sel] = data;
`ifdef STATUS_STICKY_EN
    if (sel == 2'd0) m_status = 8'h00;
`endif
    $display("load reg%0d=%h", sel, data);
  endtask

  // Entered and left just after a falling edge.
  task automatic run_cmd(input logic [3:0] rs, input logic [3:0] op, input logic [1:0] dst, input bit noise);
    logic [8:0] r;
    logic [7:0] fl;
    bit ill;
    int lat;
    r   = alu_f(op, m_reg[rs[3:2]], m_reg[rs[1:0]]);
    ill = (op >= 4'd12);
    fl  = 8'h00;
    if (op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd11}) fl[1] = (r[7:0] == 8'h00);
    if (op == 4'd2 || op == 4'd11) fl[2] = r[8];
    if (op == 4'd3) fl[0] = r[8];
    cmd_valid = 1'b1; cmd_regsel = rs; cmd_op = op; cmd_dst = dst;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_issue", busy, 1);
    chk("cmd_ready_busy", cmd_ready, 0);
    chk("alu_regsel", alu_regsel, rs);
    chk("alu_op", alu_op, op);
    if (noise) begin
      ld_valid = 1'b1; ld_sel = 2'($urandom_range(0, 3)); ld_data = 8'($urandom);
    end
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      ld_valid = 1'b0;
      lat++;
    end
    ld_valid = 1'b0;
    chk("done_latency", lat, SETTLE + 2);
    chk("err", err, ill);
    if (!ill) begin
      if (op != 4'd4) m_reg[dst] = r[7:0];
`ifdef STATUS_STICKY_EN
      m_status = m_status | fl;
`else
      m_status = fl;
`endif
    end
    chk_state();
    $display("cmd op=%h rs=%h dst=%0d res=%h err=%0b status=%h", op, rs, dst, r[7:0], ill, m_status);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    chk("err_after", err, 0);
    chk("cmd_ready_after", cmd_ready, 1);
  endtask

  initial begin
    bit any_done;
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_status = 8'h00;

    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_alu_op", alu_op, 0);
    chk_state();
    rst = 1'b0;
    @(negedge clk);

    do_load(2'd0, 8'h05); do_load(2'd1, 8'h03);
    run_cmd(4'b0001, 4'b1011, 2'd2, 1'b0);
    chk("tp1_c", reg_c, 8'h08);
    chk("tp1_status", status, 8'h00);

    do_load(2'd0, 8'hFF); do_load(2'd1, 8'h01);
    run_cmd(4'b0001, 4'b1011, 2'd3, 1'b0);
    chk("tp2_d", reg_d, 8'h00);
    chk("tp2_status", status, 8'h06);

    do_load(2'd0, 8'h02); do_load(2'd1, 8'h05);
    run_cmd(4'b0001, 4'b0011, 2'd0, 1'b0);
    chk("tp3_a", reg_a, 8'hFD);
    chk("tp3_status", status, 8'h01);

    run_cmd(4'b0110, 4'b1101, 2'd1, 1'b0);

    // Load and command offered together: load wins, command goes next cycle.
    ld_valid = 1'b1; ld_sel = 2'd1; ld_data = 8'h5A;
    cmd_valid = 1'b1; cmd_regsel = 4'b0001; cmd_op = 4'b1011; cmd_dst = 2'd3;
    #1 chk("collide_ready", cmd_ready, 0);
    @(posedge clk); @(negedge clk);
    ld_valid = 1'b0;
    m_reg[1] = 8'h5A;
    chk("collide_load", reg_b, 8'h5A);
    chk("collide_idle", busy, 0);
    run_cmd(4'b0001, 4'b1011, 2'd3, 1'b0);

    // Two adds: the first carries, the second does not.
    do_load(2'd0, 8'hFF); do_load(2'd1, 8'h01);
    run_cmd(4'b0001, 4'b1011, 2'd2, 1'b0);
    run_cmd(4'b1001, 4'b1011, 2'd3, 1'b0);
`ifdef STATUS_STICKY_EN
    chk("sticky_carry", status[2], 1);
`else
    chk("sticky_carry", status[2], 0);
`endif

    // Reset in the middle of a command.
    do_load(2'd0, 8'h11); do_load(2'd2, 8'h22);
    cmd_valid = 1'b1; cmd_regsel = 4'b0010; cmd_op = 4'b1011; cmd_dst = 2'd1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_status = 8'h00;
    #1;
    chk_state();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_alu_op", alu_op, 0);
    @(negedge clk);
    rst = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      any_done |= done;
    end
    chk("mid_rst_no_done", any_done, 0);
    chk("mid_rst_idle_ready", cmd_ready, 1);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      else
        run_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_writeback_ctrl.md
Name: alu_writeback_ctrl

Overview:
Command sequencer and writer for the 4x8 operand register file (A, B, C, D) that the combinational ALU reads.
- Accepts ALU commands over a valid/ready handshake and drives the ALU's RegSel/Operation inputs.
- Waits for the combinational result to settle, then captures Result/Status and writes Result back to a destination register.
- Also provides a host load port for initialising registers.

Parameters:
SETTLE_CYCLES, 1, cycles (1..7) the ALU inputs are held before Result is sampled
DATA_W, 8, register and result width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready at rising edge
cmd_regsel  in  4  operand select {op1[1:0], op2[1:0]}, 0=A 1=B 2=C 3=D
cmd_op  in  4  ALU operation code
cmd_dst  in  2  destination register, 0=A 1=B 2=C 3=D
ld_valid  in  1  host register load strobe
ld_sel  in  2  register to load
ld_data  in  DATA_W  load value
alu_regsel  out  4  to ALU RegSel
alu_op  out  4  to ALU Operation
alu_result  in  DATA_W  from ALU Result
alu_status  in  8  from ALU Status (bit0 borrow, bit1 zero, bit2 carry)
reg_a, reg_b, reg_c, reg_d  out  DATA_W  register file contents, to ALU operand inputs
status  out  8  flags of last completed command
done  out  1  one-cycle pulse on command completion
busy  out  1  high outside IDLE
err  out  1  one-cycle pulse with done for an illegal opcode

Behaviour:
- Reset (async, rst=1): state=IDLE; reg_a..reg_d=0; status=0; alu_regsel=0; alu_op=0; done=0; err=0; busy=0; cmd_ready=0 while rst is high.
- States: IDLE, ISSUE, WRITE, DONE.
- IDLE:
  - cmd_ready=1 unless ld_valid=1.
  - ld_valid=1 writes ld_data into reg[ld_sel] at the edge and blocks commands that cycle (load wins).
  - On cmd_valid&cmd_ready: latch regsel/op/dst; drive alu_regsel/alu_op from the latch; go to ISSUE.
- ISSUE:
  - Hold alu_regsel/alu_op stable.
  - Counter loads SETTLE_CYCLES-1 on entry and decrements; at 0 go to WRITE.
- WRITE (one cycle):
  - Sample alu_result and alu_status.
  - Write-back rule:
    - op 0000-0011, 0101-1011: reg[dst] <= alu_result.
    - op 0100 (compare): no register write; status updated.
    - op 1100-1111: illegal; no write; status unchanged; err pulsed in DONE.
  - Computed status (this block computes flags; ALU sticky flags are ignored):
    - bit1 = (alu_result == 0) for ops 0000-0011, 0101-1000, 1011.
    - bit2 = alu_status[2] for ops 0010 and 1011.
    - bit0 = alu_status[0] for op 0011.
    - All other bits 0.
  - Go to DONE.
- DONE: done=1 for exactly one cycle; err=1 if illegal; return to IDLE.
  - cmd_ready stays 0 in DONE.
  - Minimum command-to-command spacing is SETTLE_CYCLES+3 cycles.
- Latency (SETTLE_CYCLES=1):
  - Accept at edge 0; ISSUE cycle 1.
  - Register write and status visible after edge 2.
  - done high in cycle 3.
- ld_valid outside IDLE is ignored (dropped, no effect).
- dst equal to an operand register is legal: operands are sampled before the write; the write occurs in WRITE only.
- rst asserted mid-command: abort immediately to reset values; the partial command is lost; no done pulse.

Optional Feature:
STATUS_STICKY_EN
- Defined: status bits 0-2 are OR-accumulated across commands and cleared only by rst or a load to register A (ld_valid with ld_sel=0).
- Undefined: status is overwritten on every completed legal command.

Decomposition:
- Shared package alu_pkg:
  - opcode constants (OP_ONES=0000 ... OP_ADD=1011)
  - register index constants REG_A..REG_D
  - status bit indices ST_BORROW=0, ST_ZERO=1, ST_CARRY=2
  - state enum {IDLE, ISSUE, WRITE, DONE}
- One sub-module: regfile_4x8, a 4-entry DATA_W register file with a single write port and four parallel read outputs, async reset to 0.

Test Plan:
- Load A=0x05, B=0x03; cmd op=1011 regsel=0001 dst=2; ALU model returns 0x08 -> reg_c=0x08, status=0x00, done in cycle 3 after accept.
- Load A=0xFF, B=0x01; op=1011 regsel=0001 dst=3; model returns 0x00, carry=1 -> reg_d=0x00, status=0x06.
- Load A=0x02, B=0x05; op=0011 regsel=0001 dst=0; model returns 0xFD, borrow=1 -> reg_a=0xFD, status=0x01.
- op=1101 -> err and done pulse together; registers and status unchanged; cmd_ready low during busy, back high next IDLE cycle.
- ld_valid and cmd_valid both high in IDLE -> load applied, cmd_ready=0, command accepted the next cycle.
- rst pulsed during ISSUE -> all registers 0, no done, busy=0; with STATUS_STICKY_EN, two adds (carry then no carry) -> status bit2 remains 1.
